// File: rtl/cpu_state_dumper.sv
// cpu_state_dumper: streams the register file and one datamem word out as a framed UART 8N1 byte sequence.
// Optional trailing XOR checksum byte is enabled by defining DUMP_CHKSUM_EN.
module cpu_state_dumper #(
  parameter int CLKS_PER_BIT = 16,
  parameter int NREGS        = 16,
  parameter int MEM_ADDR     = 23,
  parameter int DATA_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_busy,
  input  logic              dump_req,
  output logic              rd_sel,
  output logic [4:0]        rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              tx,
  output logic              dump_busy,
  output logic              dump_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [5:0]       LAST_WORD = 6'(NREGS);
  localparam logic [4:0]       MEM_IDX   = 5'(MEM_ADDR);

  typedef enum logic [3:0] {
    IDLE, HDR, FETCH, LOAD, START, DATA, STOP,
`ifdef DUMP_CHKSUM_EN
    CSUM,
`endif
    DONE
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [2:0]         bit_reg, bit_next;
  logic [1:0]         byte_reg, byte_next;
  logic [5:0]         word_cnt_reg, word_cnt_next;
  logic [DATA_W-1:0]  word_reg, word_next;
  logic [7:0]         shift_reg, shift_next;
  logic               busy_prev_reg;
  logic               rd_sel_reg, rd_sel_next;
  logic [4:0]         rd_addr_reg, rd_addr_next;
  logic               tx_reg, tx_next;
  logic               dump_busy_reg, dump_done_reg;
`ifdef DUMP_CHKSUM_EN
  logic [7:0]         chk_reg, chk_next;
  logic               csum_sent_reg, csum_sent_next;
`endif

  logic       trigger;
  logic       last_tick;
  logic [7:0] load_byte;

  assign trigger   = dump_req | (busy_prev_reg & ~cpu_busy);
  assign last_tick = (cnt_reg == CNT_LAST);
  assign load_byte = word_reg[{byte_reg, 3'b000} +: 8];

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    bit_next      = bit_reg;
    byte_next     = byte_reg;
    word_cnt_next = word_cnt_reg;
    word_next     = word_reg;
    shift_next    = shift_reg;
    rd_sel_next   = rd_sel_reg;
    rd_addr_next  = rd_addr_reg;
`ifdef DUMP_CHKSUM_EN
    chk_next       = chk_reg;
    csum_sent_next = csum_sent_reg;
`endif
    unique case (state_reg)
      IDLE: begin
        if (trigger) begin
          state_next    = HDR;
          word_cnt_next = '0;
          byte_next     = '0;
`ifdef DUMP_CHKSUM_EN
          chk_next       = '0;
          csum_sent_next = 1'b0;
`endif
        end
      end
      HDR: begin
        shift_next = 8'hA5;
        cnt_next   = '0;
        state_next = START;
      end
      FETCH: begin
        word_next     = rd_data;
        word_cnt_next = word_cnt_reg + 6'd1;
        byte_next     = '0;
        state_next    = LOAD;
      end
      LOAD: begin
        shift_next = load_byte;
`ifdef DUMP_CHKSUM_EN
        chk_next   = chk_reg ^ load_byte;
`endif
        cnt_next   = '0;
        state_next = START;
      end
      START: begin
        cnt_next = cnt_reg + 1'b1;
        if (last_tick) begin
          cnt_next   = '0;
          bit_next   = '0;
          state_next = DATA;
        end
      end
      DATA: begin
        cnt_next = cnt_reg + 1'b1;
        if (last_tick) begin
          cnt_next   = '0;
          shift_next = {1'b0, shift_reg[7:1]};
          bit_next   = bit_reg + 3'd1;
          if (bit_reg == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        cnt_next = cnt_reg + 1'b1;
        if (last_tick) begin
          cnt_next = '0;
          // word_cnt is the index of the next word to fetch; 0 means only the header has gone out
          if (word_cnt_reg == 6'd0 || (byte_reg == 2'd3 && word_cnt_reg <= LAST_WORD)) begin
            state_next   = FETCH;
            rd_sel_next  = (word_cnt_reg == LAST_WORD);
            rd_addr_next = (word_cnt_reg == LAST_WORD) ? MEM_IDX : word_cnt_reg[4:0];
          end else if (byte_reg != 2'd3) begin
            byte_next  = byte_reg + 2'd1;
            state_next = LOAD;
          end else begin
`ifdef DUMP_CHKSUM_EN
            state_next = csum_sent_reg ? DONE : CSUM;
`else
            state_next = DONE;
`endif
          end
        end
      end
`ifdef DUMP_CHKSUM_EN
      CSUM: begin
        shift_next     = chk_reg;
        csum_sent_next = 1'b1;
        cnt_next       = '0;
        state_next     = START;
      end
`endif
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Line level registered from the upcoming state so tx changes cleanly on the edge
    tx_next = 1'b1;
    if (state_next == START)     tx_next = 1'b0;
    else if (state_next == DATA) tx_next = shift_next[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      bit_reg       <= '0;
      byte_reg      <= '0;
      word_cnt_reg  <= '0;
      word_reg      <= '0;
      shift_reg     <= '0;
      busy_prev_reg <= 1'b0;
      rd_sel_reg    <= 1'b0;
      rd_addr_reg   <= '0;
      tx_reg        <= 1'b1;
      dump_busy_reg <= 1'b0;
      dump_done_reg <= 1'b0;
`ifdef DUMP_CHKSUM_EN
      chk_reg       <= '0;
      csum_sent_reg <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bit_reg       <= bit_next;
      byte_reg      <= byte_next;
      word_cnt_reg  <= word_cnt_next;
      word_reg      <= word_next;
      shift_reg     <= shift_next;
      busy_prev_reg <= cpu_busy;
      rd_sel_reg    <= rd_sel_next;
      rd_addr_reg   <= rd_addr_next;
      tx_reg        <= tx_next;
      dump_busy_reg <= (state_next != IDLE) && (state_next != DONE);
      dump_done_reg <= (state_next == DONE);
`ifdef DUMP_CHKSUM_EN
      chk_reg       <= chk_next;
      csum_sent_reg <= csum_sent_next;
`endif
    end
  end

  assign rd_sel    = rd_sel_reg;
  assign rd_addr   = rd_addr_reg;
  assign tx        = tx_reg;
  assign dump_busy = dump_busy_reg;
  assign dump_done = dump_done_reg;

endmodule

// File: tb/tb_cpu_state_dumper.sv
// Bench for cpu_state_dumper: UART line decoder feeding a byte scoreboard, plus frame timing checks.
module tb_cpu_state_dumper;
  localparam int CPB      = 4;
  localparam int NREGS    = 16;
  localparam int MEM_ADDR = 23;
`ifdef DUMP_CHKSUM_EN
  localparam int CHK_BYTES = 1;
`else
  localparam int CHK_BYTES = 0;
`endif
  localparam int FRAME_LEN = 1 + 4 * (NREGS + 1) + CHK_BYTES;
  // HDR + header byte, then per word FETCH+LOAD+byte and three LOAD+byte, then CSUM+byte
  localparam int BUSY_CYC  = 1 + 10 * CPB + (NREGS + 1) * (2 + 10 * CPB + 3 * (1 + 10 * CPB))
                             + CHK_BYTES * (1 + 10 * CPB);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_busy = 1'b0;
  logic        dump_req = 1'b0;
  logic        rd_sel;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        tx, dump_busy, dump_done;

  logic [31:0] regs [0:31];
  logic [31:0] mem_word;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];
  int rx_bytes = 0, done_cnt = 0, busy_cycles = 0;
  logic       rx_active;
  int         rx_t;
  logic [7:0] rx_sh;

  always #5 clk = ~clk;

  assign rd_data = rd_sel ? ((rd_addr == 5'(MEM_ADDR)) ? mem_word : 32'hDEAD_BEEF) : regs[rd_addr];

  cpu_state_dumper #(.CLKS_PER_BIT(CPB), .NREGS(NREGS), .MEM_ADDR(MEM_ADDR), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .cpu_busy(cpu_busy), .dump_req(dump_req),
    .rd_sel(rd_sel), .rd_addr(rd_addr), .rd_data(rd_data),
    .tx(tx), .dump_busy(dump_busy), .dump_done(dump_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic rx_byte_done();
    logic [7:0] e;
    chk("rx_stop_bit", 32'(tx), 32'd1);
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("FAIL rx_extra_byte observed=0x%0h expected=none", rx_sh);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      $display("byte %0d rx=0x%02h exp=0x%02h", rx_bytes, rx_sh, e);
      chk("rx_byte", 32'(rx_sh), 32'(e));
    end
  endtask

  // Line decoder: start detected at t=0, each bit sampled mid-period
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      rx_active <= 1'b0;
      rx_t      <= 0;
    end else if (!rx_active) begin
      if (tx == 1'b0) begin
        rx_active <= 1'b1;
        rx_t      <= 1;
      end
    end else begin
      rx_t <= rx_t + 1;
      if (rx_t % CPB == CPB / 2) begin
        if (rx_t / CPB >= 1 && rx_t / CPB <= 8) begin
          rx_sh[3'(rx_t / CPB - 1)] <= tx;
        end else if (rx_t / CPB == 9) begin
          rx_byte_done();
          rx_bytes  <= rx_bytes + 1;
          rx_active <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (dump_done) done_cnt <= done_cnt + 1;
    if (dump_busy) busy_cycles <= busy_cycles + 1;
  end

  task automatic push_frame();
    logic [31:0] w;
    logic [7:0]  b;
    logic [7:0]  c;
    c = 8'h00;
    exp_q.push_back(8'hA5);
    for (int wi = 0; wi <= NREGS; wi++) begin
      w = (wi < NREGS) ? regs[wi] : mem_word;
      for (int bi = 0; bi < 4; bi++) begin
        b = w[8 * bi +: 8];
        exp_q.push_back(b);
        c = c ^ b;
      end
    end
    if (CHK_BYTES != 0) exp_q.push_back(c);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (dump_done !== 1'b1 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < 6000), 32'd1);
    chk({tag, "_busy_low"}, 32'(dump_busy), 32'd0);
  endtask

  task automatic wait_rx(input int target, input string tag);
    int n;
    n = 0;
    while (rx_bytes < target && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < 6000), 32'd1);
  endtask

  task automatic pulse_req();
    @(negedge clk);
    dump_req = 1'b1;
    @(negedge clk);
    dump_req = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int r0, input int d0, input int b0);
    repeat (60) @(negedge clk);
    chk({tag, "_bytes"}, 32'(rx_bytes - r0), 32'(FRAME_LEN));
    chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_busy_cycles"}, 32'(busy_cycles - b0), 32'(BUSY_CYC));
    chk({tag, "_no_restart"}, 32'(dump_busy), 32'd0);
    chk({tag, "_rd_sel_hold"}, 32'(rd_sel), 32'd1);
    chk({tag, "_rd_addr_hold"}, 32'(rd_addr), 32'(MEM_ADDR));
  endtask

  initial begin
    int r0, d0, b0;
    for (int i = 0; i < 32; i++) regs[i] = 32'(i);
    mem_word = 32'h1234_5678;

    // Reset held, then idle with cpu_busy low
    repeat (5) begin
      @(negedge clk);
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_busy", 32'(dump_busy), 32'd0);
      chk("rst_done", 32'(dump_done), 32'd0);
    end
    chk("rst_rd_sel", 32'(rd_sel), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_no_dump", 32'(dump_busy), 32'd0);
    chk("idle_no_bytes", 32'(rx_bytes), 32'd0);

    // Frame 1: cpu_busy falling edge, extra triggers mid-frame are ignored
    r0 = rx_bytes; d0 = done_cnt; b0 = busy_cycles;
    push_frame();
    cpu_busy = 1'b1;
    repeat (3) @(negedge clk);
    cpu_busy = 1'b0;
    @(negedge clk);
    chk("trig_busy_rise", 32'(dump_busy), 32'd1);
    chk("trig_tx_idle", 32'(tx), 32'd1);
    @(negedge clk);
    chk("trig_hdr_start", 32'(tx), 32'd0);
    repeat (500) @(negedge clk);
    pulse_req();
    cpu_busy = 1'b1;
    repeat (5) @(negedge clk);
    cpu_busy = 1'b0;
    wait_done("f1_done");
    check_frame("f1", r0, d0, b0);

    // Frame 2: regfile[1]=FF only; regfile[0] changed after it was latched
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    regs[1] = 32'h0000_00FF;
    mem_word = 32'h0;
    r0 = rx_bytes; d0 = done_cnt; b0 = busy_cycles;
    push_frame();
    pulse_req();
    wait_rx(r0 + 2, "f2_wait_word0");
    regs[0] = 32'h0000_00AA;
    wait_done("f2_done");
    check_frame("f2", r0, d0, b0);

    // Frame 3: reset during the data bits of byte 10
    for (int i = 0; i < 32; i++) regs[i] = 32'h0101_0101 * 32'(i + 3);
    mem_word = 32'hCAFE_F00D;
    r0 = rx_bytes;
    push_frame();
    pulse_req();
    wait_rx(r0 + 10, "f3_wait_byte10");
    begin
      int n;
      n = 0;
      while (rx_active !== 1'b1 && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("f3_byte10_start", 32'(n < 200), 32'd1);
    end
    repeat (2 * CPB) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_tx", 32'(tx), 32'd1);
    chk("rst_mid_busy", 32'(dump_busy), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Frame 4: full frame after the aborted one
    r0 = rx_bytes; d0 = done_cnt; b0 = busy_cycles;
    push_frame();
    pulse_req();
    wait_done("f4_done");
    check_frame("f4", r0, d0, b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu_state_dumper.md
# cpu_state_dumper

Serializes the CPU's architectural state out of the chip once a program finishes: it reads the register file plus one data-memory word and streams them as a framed byte sequence on a UART 8N1 transmit line. It sits beside `cpu`, driven by `cpu_busy` and a side-band read port into `regfile`/`datamem`. It is the on-silicon transmitter of the same state dump the simulation bench prints.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per UART bit, ≥2.
- `NREGS`, 16: register entries dumped, indices 0..NREGS-1, ≤32.
- `MEM_ADDR`, 23: datamem word index dumped after the registers.
- `DATA_W`, 32: word width, fixed at 32 (4 bytes per word).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cpu_busy`  in  1  CPU busy flag; falling edge triggers a dump.
- `dump_req`  in  1  one-cycle pulse forcing a dump.
- `rd_sel`  out  1  0 selects regfile, 1 selects datamem.
- `rd_addr`  out  5  read index. Regfile index, or `MEM_ADDR[4:0]` when `rd_sel`=1.
- `rd_data`  in  32  read data, combinational from `rd_sel`/`rd_addr`.
- `tx`  out  1  UART line. Idle high.
- `dump_busy`  out  1  high from trigger until the last stop bit ends.
- `dump_done`  out  1  one-cycle pulse after the last stop bit.

## Operation
- Trigger: either `dump_req`=1, or a registered `cpu_busy` of 1 followed by a sampled 0. Both are accepted only in IDLE and are ignored while `dump_busy`=1. The previous-busy register resets to 0, so the first trigger requires a 1→0 transition.
- Frame, in order:
  - header byte 0xA5;
  - regfile[0..NREGS-1], each word LSB byte first;
  - datamem[MEM_ADDR], LSB byte first;
  - optional checksum byte (see Configuration).
- Frame length is 1+4·(NREGS+1) bytes (69 at defaults), plus one byte with the checksum.
- States:
  - IDLE → HDR on trigger.
  - HDR loads 0xA5 → START.
  - FETCH drives `rd_sel`/`rd_addr` for one cycle, latches `rd_data` into a 32-bit word register, byte index = 0 → LOAD.
  - LOAD selects `word[8·idx+7:8·idx]` → START.
  - START → DATA → STOP.
  - After STOP:
    - if more bytes remain in the word → LOAD, idx+1;
    - else if more words remain → FETCH;
    - else if checksum is enabled and not yet sent → CSUM;
    - else → DONE.
  - CSUM loads the checksum byte → START.
  - DONE pulses `dump_done` → IDLE.
- Word counter is 0..NREGS. Value NREGS selects `rd_sel`=1.
- Bit order: start bit 0, data bits LSB first, stop bit 1.
- `rd_sel`/`rd_addr` hold their last value outside FETCH. They are glitch-free registered outputs.
- `rd_data` is sampled only in the FETCH cycle. Register contents changing during the frame do not affect already-latched words.

## Timing
- Reset values: `tx`=1, `dump_busy`=0, `dump_done`=0, `rd_sel`=0, `rd_addr`=0. State is IDLE; all counters and the checksum are 0.
- Trigger seen at edge N: `dump_busy`=1 from N+1. The header's start bit begins driving `tx` at N+2.
- Each bit lasts exactly CLKS_PER_BIT cycles. Each byte lasts 10·CLKS_PER_BIT cycles.
- Overhead cycles between bytes: LOAD adds 1 cycle, FETCH+LOAD add 2 cycles. `tx` stays high during them.
- `dump_done` is asserted in the cycle after the final stop bit completes. `dump_busy` falls in that same cycle.
- Trigger coinciding with the DONE cycle is ignored.
- Reset mid-frame: `tx` returns to 1 asynchronously and all state clears. No partial-byte completion.

## Configuration
- `DUMP_CHKSUM_EN` defined: an 8-bit XOR of every data byte (header excluded) is accumulated as bytes load. It is sent as the final byte, and the accumulator clears on trigger.
- Undefined: no CSUM state and no accumulator. The frame ends after the datamem word.

## Test plan
- Reset with `rst`=1 for 5 cycles → `tx`=1, `dump_busy`=0, `dump_done`=0 throughout. `cpu_busy` held 0 → no dump starts.
- CLKS_PER_BIT=4, regfile[i]=i, datamem[23]=0x12345678, `cpu_busy` 1→0 → bytes A5, 00 00 00 00, 01 00 00 00, …, 0F 00 00 00, 78 56 34 12. Each byte is 40 cycles of framed line. `dump_done` pulses once.
- `dump_req` pulse mid-frame, plus a second `cpu_busy` fall mid-frame → byte count stays 69; no restart.
- `rst` asserted during the data bits of byte 10 → `tx`=1 the same cycle. A subsequent `dump_req` yields a full frame starting with A5.
- `DUMP_CHKSUM_EN` with regfile[1]=0xFF, all other sources 0 → 70 bytes, last byte 0xFF. Without the macro → 69 bytes.
- Change regfile[0] to 0xAA after its FETCH → transmitted bytes still reflect the latched old value.
